// File: rtl/barcode_word_reader_if.sv
// Stream/word bus between the optical sampler, the barcode reader and the word consumer.
`timescale 1ns/1ps
interface barcode_word_reader_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             b;
  logic [WIDTH-1:0] y;
  logic             valid;
  logic             err;
  logic [1:0]       err_code;
  logic [CW-1:0]    count;
  logic             busy;

  modport master (output b, input y, valid, err, err_code, count, busy);
  modport slave  (input b, output y, valid, err, err_code, count, busy);
endinterface

// File: rtl/barcode_word_reader.sv
// Serial bar/space decoder: one module per OSR clocks, words framed by BB end markers.
// Bit 0 = space,bar; bit 1 = space,space,space,bar; first received bit lands in the MSB.
`timescale 1ns/1ps
module barcode_word_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OSR   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  barcode_word_reader_if.slave  bus
);
  localparam int unsigned CW    = $clog2(WIDTH + 1);
  localparam int unsigned FIRST = OSR + OSR / 2 - 1;
  localparam int unsigned SW    = (FIRST > 0) ? $clog2(FIRST + 1) : 1;

  localparam logic [1:0] E_FRAME = 2'b00;
  localparam logic [1:0] E_OVFL  = 2'b01;
  localparam logic [1:0] E_WWB   = 2'b10;
  localparam logic [1:0] E_SPACE = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_BAR, S_W1, S_W2, S_W3, S_END, S_ERR} state_t;

  state_t           r_state;
  logic [SW-1:0]    r_scnt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_y;
  logic             r_valid;
  logic             r_err;
  logic [1:0]       r_code;
  logic [CW-1:0]    r_count;

  logic w_strobe;
  logic w_emit;
  logic w_bit;
  logic w_full;

  // Strobe every cycle while idle, otherwise at module centres tracked by the down-counter
  assign w_strobe = (r_state == S_IDLE) || (r_scnt == '0);
  assign w_emit   = w_strobe && bus.b && ((r_state == S_W1) || (r_state == S_W3));
  assign w_bit    = (r_state == S_W3);
  assign w_full   = (r_count == CW'(WIDTH));

  // Sample counter, framing FSM, shift register and registered result/error pulses
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_scnt  <= '0;
      r_sreg  <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= E_FRAME;
      r_count <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      // First strobe lands half a module into the first space after the start bar
      if (r_state == S_IDLE) begin
        if (bus.b) r_scnt <= SW'(FIRST);
      end else if (r_scnt == '0) begin
        r_scnt <= SW'(OSR - 1);
      end else begin
        r_scnt <= r_scnt - SW'(1);
      end

      if (w_strobe) begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.b) begin
              r_state <= S_BAR;
              r_sreg  <= '0;
              r_count <= '0;
            end
          end
          S_BAR: begin
            if (!bus.b) begin
              r_state <= S_W1;
            end else begin
              r_state <= S_END;
              if (w_full) begin
                r_y     <= r_sreg;
                r_valid <= 1'b1;
              end else begin
                r_err  <= 1'b1;
                r_code <= E_FRAME;
              end
            end
          end
          S_W1: begin
            if (!bus.b) r_state <= S_W2;
          end
          S_W2: begin
            if (!bus.b) begin
              r_state <= S_W3;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_code  <= E_WWB;
            end
          end
          S_W3: begin
            if (!bus.b) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_code  <= E_SPACE;
            end
          end
          S_END: begin
            if (bus.b) begin
              r_state <= S_BAR;
              r_sreg  <= '0;
              r_count <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_ERR: begin
            if (!bus.b) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase

        // A completed bit either shifts in or overflows a full word
        if (w_emit) begin
          if (w_full) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_code  <= E_OVFL;
          end else begin
            r_state <= S_BAR;
            r_sreg  <= WIDTH'({r_sreg, w_bit});
            r_count <= r_count + CW'(1);
          end
        end
      end
    end
  end

  assign bus.y        = r_y;
  assign bus.valid    = r_valid;
  assign bus.err      = r_err;
  assign bus.err_code = r_code;
  assign bus.count    = r_count;
  assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_barcode_word_reader.sv
// Scoreboard bench for barcode_word_reader: three instances cover WIDTH/OSR corners.
`timescale 1ns/1ps
module tb_barcode_word_reader;
  typedef struct {
    bit         is_valid;
    logic [1:0] code;
    logic [7:0] y;
    logic [3:0] cnt;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  barcode_word_reader_if #(.WIDTH(4)) if_a ();
  barcode_word_reader_if #(.WIDTH(2)) if_b ();
  barcode_word_reader_if #(.WIDTH(2)) if_c ();

  barcode_word_reader #(.WIDTH(4), .OSR(1)) u_a (.i_clk(clk), .i_rst(rst_n), .bus(if_a.slave));
  barcode_word_reader #(.WIDTH(2), .OSR(1)) u_b (.i_clk(clk), .i_rst(rst_n), .bus(if_b.slave));
  barcode_word_reader #(.WIDTH(2), .OSR(4)) u_c (.i_clk(clk), .i_rst(rst_n), .bus(if_c.slave));

  int n_checks = 0;
  int n_fail   = 0;
  ev_t q_a[$];
  ev_t q_b[$];
  ev_t q_c[$];
  logic [7:0] last_y [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int osr_of(input int d);
    return (d == 2) ? 4 : 1;
  endfunction

  task automatic set_b(input int d, input logic v);
    case (d)
      0:       if_a.b = v;
      1:       if_b.b = v;
      default: if_c.b = v;
    endcase
  endtask

  // One module of value v; with g set the first clock is inverted (off-centre glitch)
  task automatic mod(input int d, input logic v, input bit g);
    for (int i = 0; i < osr_of(d); i++) begin
      set_b(d, (g && i == 0) ? ~v : v);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_body(input int d, input logic [7:0] bits, input int nb, input bit g);
    mod(d, 1'b1, 1'b0);
    for (int k = nb - 1; k >= 0; k--) begin
      if (bits[k]) begin
        mod(d, 1'b0, g); mod(d, 1'b0, g); mod(d, 1'b0, g); mod(d, 1'b1, g);
      end else begin
        mod(d, 1'b0, g); mod(d, 1'b1, g);
      end
    end
  endtask

  task automatic frame(input int d, input logic [7:0] bits, input int nb, input bit g);
    frame_body(d, bits, nb, g);
    mod(d, 1'b1, g);
  endtask

  task automatic expect_ev(input int d, input bit v, input logic [1:0] code,
                           input logic [7:0] y, input logic [3:0] cnt);
    ev_t e;
    e.is_valid = v;
    e.code     = code;
    e.y        = v ? y : last_y[d];
    e.cnt      = cnt;
    if (v) last_y[d] = y;
    case (d)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic observe(input int d, input logic v, input logic e, input logic [1:0] c,
                         input logic [7:0] y, input logic [3:0] n);
    ev_t x;
    bit  have;
    if (!(v || e)) return;
    have = 1'b0;
    case (d)
      0:       if (q_a.size() > 0) begin x = q_a.pop_front(); have = 1'b1; end
      1:       if (q_b.size() > 0) begin x = q_b.pop_front(); have = 1'b1; end
      default: if (q_c.size() > 0) begin x = q_c.pop_front(); have = 1'b1; end
    endcase
    chk($sformatf("d%0d_excl", d), 32'(v && e), 32'd0);
    chk($sformatf("d%0d_expected_pulse", d), 32'(have), 32'd1);
    if (have) begin
      chk($sformatf("d%0d_kind", d), 32'(v), 32'(x.is_valid));
      chk($sformatf("d%0d_y", d), 32'(y), 32'(x.y));
      chk($sformatf("d%0d_count", d), 32'(n), 32'(x.cnt));
      if (!x.is_valid) chk($sformatf("d%0d_code", d), 32'(c), 32'(x.code));
    end
  endtask

  // Pop and compare on every valid/err pulse
  always @(negedge clk) begin
    if (rst_n) begin
      observe(0, if_a.valid, if_a.err, if_a.err_code, 8'(if_a.y), 4'(if_a.count));
      observe(1, if_b.valid, if_b.err, if_b.err_code, 8'(if_b.y), 4'(if_b.count));
      observe(2, if_c.valid, if_c.err, if_c.err_code, 8'(if_c.y), 4'(if_c.count));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] pat;
    for (int d = 0; d < 3; d++) last_y[d] = 8'h00;
    if_a.b = 1'b0; if_b.b = 1'b0; if_c.b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", 32'(if_a.y), 32'd0);
    chk("rst_valid", 32'(if_a.valid), 32'd0);
    chk("rst_err", 32'(if_a.err), 32'd0);
    chk("rst_code", 32'(if_a.err_code), 32'd0);
    chk("rst_count", 32'(if_a.count), 32'd0);
    chk("rst_busy", 32'(if_a.busy), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Word decode with cycle-exact busy and valid timing
    pat = 14'b10001010001011;
    expect_ev(0, 1'b1, 2'b00, 8'h0A, 4'd4);
    chk("busy_before", 32'(if_a.busy), 32'd0);
    for (int i = 13; i >= 0; i--) begin
      set_b(0, pat[i]);
      @(posedge clk); #1;
      chk("busy_frame", 32'(if_a.busy), 32'd1);
      chk("valid_timing", 32'(if_a.valid), 32'(i == 0));
    end
    mod(0, 1'b0, 1'b0);
    chk("busy_after", 32'(if_a.busy), 32'd0);

    // Short frame and immediate end marker
    expect_ev(0, 1'b0, 2'b00, 8'h00, 4'd2);
    frame(0, 8'b00, 2, 1'b0);
    mod(0, 1'b0, 1'b0);
    chk("count_hold_idle", 32'(if_a.count), 32'd2);
    chk("y_hold", 32'(if_a.y), 32'hA);
    expect_ev(0, 1'b0, 2'b00, 8'h00, 4'd0);
    mod(0, 1'b1, 1'b0); mod(0, 1'b1, 1'b0); mod(0, 1'b0, 1'b0);

    // Back-to-back frames through END->BAR
    expect_ev(0, 1'b1, 2'b00, 8'h06, 4'd4);
    expect_ev(0, 1'b1, 2'b00, 8'h09, 4'd4);
    frame(0, 8'b0110, 4, 1'b0);
    frame(0, 8'b1001, 4, 1'b0);
    mod(0, 1'b0, 1'b0);
    chk("y_b2b", 32'(if_a.y), 32'h9);

    // Overflow on WIDTH=2
    expect_ev(1, 1'b0, 2'b01, 8'h00, 4'd2);
    mod(1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin mod(1, 1'b0, 1'b0); mod(1, 1'b1, 1'b0); end
    chk("ovfl_busy", 32'(if_b.busy), 32'd1);
    mod(1, 1'b0, 1'b0);
    chk("ovfl_idle", 32'(if_b.busy), 32'd0);

    // Bad WWB pattern after one bit, then ERR held by bars
    expect_ev(1, 1'b0, 2'b10, 8'h00, 4'd1);
    mod(1, 1'b1, 1'b0); mod(1, 1'b0, 1'b0); mod(1, 1'b1, 1'b0);
    mod(1, 1'b0, 1'b0); mod(1, 1'b0, 1'b0); mod(1, 1'b1, 1'b0);
    repeat (3) mod(1, 1'b1, 1'b0);
    chk("err_hold_busy", 32'(if_b.busy), 32'd1);
    chk("err_code_hold", 32'(if_b.err_code), 32'd2);
    mod(1, 1'b0, 1'b0);
    chk("err_exit_busy", 32'(if_b.busy), 32'd0);

    // Space too long
    expect_ev(1, 1'b0, 2'b11, 8'h00, 4'd0);
    mod(1, 1'b1, 1'b0);
    repeat (4) mod(1, 1'b0, 1'b0);
    mod(1, 1'b0, 1'b0);
    chk("space_exit_busy", 32'(if_b.busy), 32'd0);

    // Oversampled decode, clean then with off-centre glitches
    for (int g = 0; g < 2; g++) begin
      expect_ev(2, 1'b1, 2'b00, 8'h02, 4'd2);
      frame_body(2, 8'b10, 2, bit'(g));
      for (int i = 0; i < 4; i++) begin
        set_b(2, (g == 1 && i == 0) ? 1'b0 : 1'b1);
        @(posedge clk); #1;
        chk("osr_strobe", 32'(if_c.valid), 32'(i == 2));
      end
      mod(2, 1'b0, bit'(g));
      mod(2, 1'b0, 1'b0);
      chk("osr_idle", 32'(if_c.busy), 32'd0);
    end
    chk("osr_y", 32'(if_c.y), 32'h2);

    // Asynchronous reset mid-frame, then normal decode
    mod(0, 1'b1, 1'b0); mod(0, 1'b0, 1'b0); mod(0, 1'b1, 1'b0); mod(0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(if_a.y), 32'd0);
    chk("arst_count", 32'(if_a.count), 32'd0);
    chk("arst_busy", 32'(if_a.busy), 32'd0);
    chk("arst_valid", 32'(if_a.valid), 32'd0);
    chk("arst_err", 32'(if_a.err), 32'd0);
    chk("arst_code", 32'(if_a.err_code), 32'd0);
    for (int d = 0; d < 3; d++) last_y[d] = 8'h00;
    set_b(0, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    expect_ev(0, 1'b1, 2'b00, 8'h0D, 4'd4);
    frame(0, 8'b1101, 4, 1'b0);
    mod(0, 1'b0, 1'b0);
    chk("post_rst_y", 32'(if_a.y), 32'hD);

    repeat (4) @(posedge clk);
    #1;
    chk("q_a_empty", 32'(q_a.size()), 32'd0);
    chk("q_b_empty", 32'(q_b.size()), 32'd0);
    chk("q_c_empty", 32'(q_c.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
